// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
// Operation encodings match the controller's mul_ctrl field.
package mul_pkg;
    localparam int XLEN     = 32;
    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;
endpackage

// File: rtl/mul_unit_sign_cond.sv
// Operand conditioning: conceptual 33-bit extension of each source, then
// magnitude and product sign for the unsigned shift-add core.
module mul_sign_cond
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  mul_op_e         op,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg
);
    logic signed_a;
    logic signed_b;
    logic sign_a;
    logic sign_b;

    always_comb begin
        signed_a = (op == MULH) || (op == MULHSU);
        signed_b = (op == MULH);
        // Bit 32 of the extended operand; zero whenever the operand is unsigned.
        sign_a   = signed_a & src1[XLEN-1];
        sign_b   = signed_b & src2[XLEN-1];
        mag_a    = sign_a ? (~src1 + 32'd1) : src1;
        mag_b    = sign_b ? (~src2 + 32'd1) : src2;
        neg      = sign_a ^ sign_b;
    end
endmodule

// File: rtl/mul_unit.sv
// Multi-cycle RV32M multiplier: 32-step radix-2 shift-add on magnitudes,
// sign fix-up and slice select, then a one-cycle result_valid pulse.
module mul_unit
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mul_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    mul_state_e        state;
    mul_state_e        state_nxt;
    logic [5:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg_q;
    mul_op_e           op_q;
    mul_op_e           op_in;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg;
    logic              accept;
    logic [2*XLEN-1:0] prod;

    assign op_in = mul_op_e'(mul_ctrl);

    mul_sign_cond u_sign_cond (
        .src1  (src1),
        .src2  (src2),
        .op    (op_in),
        .mag_a (mag_a),
        .mag_b (mag_b),
        .neg   (neg)
    );

    always_comb begin
        state_nxt    = state;
        accept       = start && !kill && (state == IDLE);
        busy         = (state != IDLE);
        stall        = !rst && (accept || (state == CALC) || (state == FIX));
        // Still pulses if killed in DONE; the consumer squashes the write.
        result_valid = !rst && (state == DONE);
        prod         = neg_q ? (~acc + 64'd1) : acc;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (kill)                             state_nxt = IDLE;
                else if (count == 6'(MUL_ITER - 1))   state_nxt = FIX;
            end
            FIX:  state_nxt = kill ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg_q  <= 1'b0;
            op_q   <= MUL;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    count  <= '0;
                    acc    <= '0;
                    mcand  <= {{XLEN{1'b0}}, mag_a};
                    mplier <= mag_b;
                    neg_q  <= neg;
                    op_q   <= op_in;
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 6'd1;
                end
                FIX: if (!kill) begin
                    result <= (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end
endmodule
